// File: rtl/mips_multicycle_control_pkg.sv
// mips_multicycle_control_pkg: shared opcode/funct, ALU, state and decode-class definitions
package mips_multicycle_control_pkg;
    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_EXCEPT = 3'd5
    } state_t;

    typedef enum logic [3:0] {
        CL_BAD, CL_ALU, CL_IMM, CL_BEQ, CL_BNE, CL_J, CL_JR, CL_LOAD, CL_STORE
    } class_t;

    localparam logic [2:0] ALU_ADD = 3'd2, ALU_SUB = 3'd3, ALU_AND = 3'd4,
                           ALU_OR  = 3'd5, ALU_NOR = 3'd6, ALU_XOR = 3'd7;

    localparam logic [5:0] OP_OTHER0 = 6'h00, OP_J = 6'h02, OP_BEQ = 6'h04, OP_BNE = 6'h05,
                           OP_ADDI = 6'h08, OP_SLTI = 6'h0a, OP_ANDI = 6'h0c, OP_ORI = 6'h0d,
                           OP_XORI = 6'h0e, OP_LUI = 6'h0f, OP_LW = 6'h23, OP_LBU = 6'h24,
                           OP_SB = 6'h28, OP_SW = 6'h2b;

    localparam logic [5:0] OP0_JR = 6'h08, OP0_ADD = 6'h20, OP0_SUB = 6'h22, OP0_AND = 6'h24,
                           OP0_OR = 6'h25, OP0_XOR = 6'h26, OP0_NOR = 6'h27, OP0_SLT = 6'h2a,
                           OP0_ADDM = 6'h2c;

    typedef struct packed {
        class_t     cls;
        logic [2:0] alu_op;
        logic       rd_src;
        logic       alu_src2;
        logic       slt;
        logic       lui;
        logic       addm;
        logic       byte_load;
        logic       byte_store;
    } ctrl_t;
endpackage

// File: rtl/mips_multicycle_control_decode_class.sv
// mips_multicycle_control_decode_class: opcode/funct -> instruction class and static control fields
module mips_multicycle_control_decode_class
    import mips_multicycle_control_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output ctrl_t      ctrl
);
    always_comb begin
        ctrl = '0;
        case (opcode)
            OP_OTHER0: case (funct)
                OP0_ADD:  begin ctrl.cls = CL_ALU; ctrl.alu_op = ALU_ADD; end
                OP0_SUB:  begin ctrl.cls = CL_ALU; ctrl.alu_op = ALU_SUB; end
                OP0_AND:  begin ctrl.cls = CL_ALU; ctrl.alu_op = ALU_AND; end
                OP0_OR:   begin ctrl.cls = CL_ALU; ctrl.alu_op = ALU_OR; end
                OP0_XOR:  begin ctrl.cls = CL_ALU; ctrl.alu_op = ALU_XOR; end
                OP0_NOR:  begin ctrl.cls = CL_ALU; ctrl.alu_op = ALU_NOR; end
                OP0_SLT:  begin ctrl.cls = CL_ALU; ctrl.alu_op = ALU_SUB; ctrl.slt = 1'b1; end
                OP0_JR:   ctrl.cls = CL_JR;
                OP0_ADDM: begin ctrl.cls = CL_LOAD; ctrl.alu_op = ALU_ADD; ctrl.addm = 1'b1; end
                default:  ;
            endcase
            OP_J:    ctrl.cls = CL_J;
            OP_BEQ:  begin ctrl.cls = CL_BEQ; ctrl.alu_op = ALU_SUB; end
            OP_BNE:  begin ctrl.cls = CL_BNE; ctrl.alu_op = ALU_SUB; end
            OP_ADDI: begin ctrl.cls = CL_IMM; ctrl.alu_op = ALU_ADD; ctrl.rd_src = 1'b1; ctrl.alu_src2 = 1'b1; end
            OP_SLTI: begin ctrl.cls = CL_IMM; ctrl.alu_op = ALU_SUB; ctrl.rd_src = 1'b1; ctrl.alu_src2 = 1'b1; ctrl.slt = 1'b1; end
            OP_ANDI: begin ctrl.cls = CL_IMM; ctrl.alu_op = ALU_AND; ctrl.rd_src = 1'b1; ctrl.alu_src2 = 1'b1; end
            OP_ORI:  begin ctrl.cls = CL_IMM; ctrl.alu_op = ALU_OR; ctrl.rd_src = 1'b1; ctrl.alu_src2 = 1'b1; end
            OP_XORI: begin ctrl.cls = CL_IMM; ctrl.alu_op = ALU_XOR; ctrl.rd_src = 1'b1; ctrl.alu_src2 = 1'b1; end
            OP_LUI:  begin ctrl.cls = CL_IMM; ctrl.rd_src = 1'b1; ctrl.lui = 1'b1; end
            OP_LW:   begin ctrl.cls = CL_LOAD; ctrl.alu_op = ALU_ADD; ctrl.rd_src = 1'b1; ctrl.alu_src2 = 1'b1; end
            OP_LBU:  begin ctrl.cls = CL_LOAD; ctrl.alu_op = ALU_ADD; ctrl.rd_src = 1'b1; ctrl.alu_src2 = 1'b1; ctrl.byte_load = 1'b1; end
            OP_SW:   begin ctrl.cls = CL_STORE; ctrl.alu_op = ALU_ADD; ctrl.alu_src2 = 1'b1; end
            OP_SB:   begin ctrl.cls = CL_STORE; ctrl.alu_op = ALU_ADD; ctrl.alu_src2 = 1'b1; ctrl.byte_store = 1'b1; end
            default: ;
        endcase
    end
endmodule

// File: rtl/mips_multicycle_control.sv
// mips_multicycle_control: multi-cycle FSM sequencing FETCH/DECODE/EXEC/MEM/WB control
// Outputs are decoded from the current state, so a stalled state replays its strobes on resume.
module mips_multicycle_control
    import mips_multicycle_control_pkg::*;
#(
    parameter int MEM_LAT = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       stall,
    output logic [2:0] state,
    output logic [2:0] alu_op,
    output logic       rd_src,
    output logic       alu_src2,
    output logic       slt,
    output logic       lui,
    output logic       addm,
    output logic       byte_load,
    output logic [1:0] control_type,
    output logic       mem_read,
    output logic       word_we,
    output logic       byte_we,
    output logic       writeenable,
    output logic       except,
    output logic       ir_we,
    output logic       pc_we
);
    localparam int CNT_W = $clog2(MEM_LAT + 1);

    state_t           st, nxt;
    logic [CNT_W-1:0] cnt;
    logic [5:0]       op_q, fn_q;
    ctrl_t            c;
    logic             last, first, taken;

    // DECODE classifies the live IR; later states use the latched copy
    mips_multicycle_control_decode_class u_dec (
        .opcode(st == S_DECODE ? opcode : op_q),
        .funct (st == S_DECODE ? funct : fn_q),
        .ctrl  (c)
    );

    assign last  = cnt == CNT_W'(MEM_LAT - 1);
    assign first = cnt == '0;
    assign taken = c.cls == CL_BEQ ? zero : !zero;
    assign state = reset ? S_FETCH : st;

    always_ff @(posedge clk) begin
        if (reset) begin
            st   <= S_FETCH;
            cnt  <= '0;
            op_q <= '0;
            fn_q <= '0;
        end else if (!stall) begin
            st  <= nxt;
            cnt <= nxt != st ? '0 : cnt + 1'b1;
            if (st == S_DECODE) begin
                op_q <= opcode;
                fn_q <= funct;
            end
        end
    end

    always_comb begin
        nxt = st;
        {alu_op, rd_src, alu_src2, slt, lui, addm, byte_load, control_type, mem_read} = '0;
        {word_we, byte_we, writeenable, except, ir_we, pc_we} = '0;
        case (st)
            S_FETCH: begin
                ir_we = last;
                nxt   = last ? S_DECODE : S_FETCH;
            end
            S_DECODE: nxt = c.cls == CL_BAD ? S_EXCEPT : S_EXEC;
            S_EXEC: begin
                {alu_op, rd_src, alu_src2, slt, lui} = {c.alu_op, c.rd_src, c.alu_src2, c.slt, c.lui};
                case (c.cls)
                    CL_BEQ, CL_BNE: begin pc_we = 1'b1; control_type = taken ? 2'b01 : 2'b00; nxt = S_FETCH; end
                    CL_J:           begin pc_we = 1'b1; control_type = 2'b10; nxt = S_FETCH; end
                    CL_JR:          begin pc_we = 1'b1; control_type = 2'b11; nxt = S_FETCH; end
                    CL_LOAD, CL_STORE: nxt = S_MEM;
                    default:        nxt = S_WB;
                endcase
            end
            S_MEM: begin
                if (c.cls == CL_STORE) begin
                    word_we = first && !c.byte_store;
                    byte_we = first && c.byte_store;
                    pc_we   = last;
                    nxt     = last ? S_FETCH : S_MEM;
                end else begin
                    mem_read  = 1'b1;
                    byte_load = c.byte_load;
                    addm      = c.addm;
                    nxt       = last ? S_WB : S_MEM;
                end
            end
            S_WB:     begin writeenable = 1'b1; pc_we = 1'b1; nxt = S_FETCH; end
            S_EXCEPT: begin except = 1'b1; pc_we = 1'b1; nxt = S_FETCH; end
            default:  nxt = S_FETCH;
        endcase
        if (reset || stall) {word_we, byte_we, writeenable, except, ir_we, pc_we} = '0;
        if (reset) {alu_op, rd_src, alu_src2, slt, lui, addm, byte_load, control_type, mem_read} = '0;
    end
endmodule
